// File: rtl/can_rx_frame_buffer.sv
// CAN RX frame reassembly + frame FIFO with show-ahead output register.
// Optional CAN_RX_BUF_TIMESTAMP_EN adds a per-frame 32-bit timestamp (out_ts).
module can_rx_frame_buffer #(
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [7:0]       in_data,
  input  logic [28:0]      in_id,
  input  logic             in_ide,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [28:0]      out_id,
  output logic             out_ide,
  output logic [3:0]       out_len,
  output logic [63:0]      out_data,
  output logic [ASIZE:0]   frame_cnt,
  output logic             overflow,
  output logic             len_err,
`ifdef CAN_RX_BUF_TIMESTAMP_EN
  output logic [31:0]      out_ts,
`endif
  output logic [15:0]      drop_cnt
);

  localparam int DEPTH = 1 << ASIZE;

  typedef struct packed {
`ifdef CAN_RX_BUF_TIMESTAMP_EN
    logic [31:0] ts;
`endif
    logic [28:0] id;
    logic        ide;
    logic [3:0]  len;
    logic [63:0] data;
  } frame_t;

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_t;

  state_t            r_state;
  logic [28:0]       r_id;
  logic              r_ide;
  logic [3:0]        r_cnt;
  logic [63:0]       r_data;
  logic              r_lerr_done;
  logic              r_len_err;
`ifdef CAN_RX_BUF_TIMESTAMP_EN
  logic [31:0]       r_ts_ctr;
  logic [31:0]       r_ts;
`endif

  logic [ASIZE:0]    r_wptr;
  logic [ASIZE:0]    r_wptr_vis;
  logic [ASIZE:0]    r_rptr;
  frame_t            r_mem [DEPTH];
  frame_t            r_out;
  logic              r_out_valid;
  logic              r_overflow;
  logic [15:0]       r_drop_cnt;

  frame_t            w_frame;
  logic              w_lerr;
  logic              w_commit;
  logic              w_full;
  logic              w_wr;
  logic              w_pop;
  logic              w_load;
  logic              w_avail;
  logic [ASIZE:0]    w_rd_ptr;
  logic [63:0]       w_byte64;

  assign w_byte64 = {56'd0, in_data};

  // Frame as it would look including the byte on the bus this cycle.
  always_comb begin
    w_frame = '0;
    w_lerr  = 1'b0;
    if (r_state == S_IDLE) begin
      w_frame.id   = in_id;
      w_frame.ide  = in_ide;
      w_frame.len  = 4'd1;
      w_frame.data = w_byte64;
`ifdef CAN_RX_BUF_TIMESTAMP_EN
      w_frame.ts   = r_ts_ctr;
`endif
    end else begin
      w_frame.id  = r_id;
      w_frame.ide = r_ide;
`ifdef CAN_RX_BUF_TIMESTAMP_EN
      w_frame.ts  = r_ts;
`endif
      if (r_cnt[3]) begin
        w_frame.len  = r_cnt;
        w_frame.data = r_data;
        w_lerr       = ~r_lerr_done;
      end else begin
        w_frame.len  = r_cnt + 4'd1;
        w_frame.data = r_data |
          (w_byte64 << {r_cnt[2:0], 3'b000});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      r_ide       <= 1'b0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_lerr_done <= 1'b0;
      r_len_err   <= 1'b0;
`ifdef CAN_RX_BUF_TIMESTAMP_EN
      r_ts        <= '0;
`endif
    end else begin
      r_len_err <= 1'b0;
      if (in_valid) begin
        r_id   <= w_frame.id;
        r_ide  <= w_frame.ide;
        r_cnt  <= w_frame.len;
        r_data <= w_frame.data;
`ifdef CAN_RX_BUF_TIMESTAMP_EN
        r_ts   <= w_frame.ts;
`endif
        if (w_lerr) begin
          r_len_err   <= 1'b1;
          r_lerr_done <= 1'b1;
        end
        if (in_last) begin
          r_state     <= S_IDLE;
          r_lerr_done <= 1'b0;
        end else begin
          r_state <= S_COLLECT;
        end
      end
    end
  end

`ifdef CAN_RX_BUF_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (!rstn) r_ts_ctr <= '0;
    else       r_ts_ctr <= r_ts_ctr + 32'd1;
  end
`endif

  assign w_commit = in_valid & in_last;
  assign w_full   = (r_wptr[ASIZE] != r_rptr[ASIZE]) &&
                    (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]);
  assign w_wr     = w_commit & ~w_full;
  assign w_pop    = r_out_valid & out_ready;
  assign w_rd_ptr = r_rptr + {{ASIZE{1'b0}}, w_pop};
  // r_wptr_vis lags one clk to model BRAM write-to-read latency.
  assign w_avail  = (w_rd_ptr != r_wptr_vis);
  assign w_load   = ~r_out_valid | w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[ASIZE-1:0]] <= w_frame;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr      <= '0;
      r_wptr_vis  <= '0;
      r_rptr      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_overflow <= 1'b0;
      r_wptr_vis <= r_wptr;
      if (w_commit && w_full) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF)
          r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= w_rd_ptr;
      if (w_load) begin
        r_out_valid <= w_avail;
        if (w_avail) r_out <= r_mem[w_rd_ptr[ASIZE-1:0]];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_id    = r_out.id;
  assign out_ide   = r_out.ide;
  assign out_len   = r_out.len;
  assign out_data  = r_out.data;
`ifdef CAN_RX_BUF_TIMESTAMP_EN
  assign out_ts    = r_out.ts;
`endif
  assign frame_cnt = r_wptr - r_rptr;
  assign overflow  = r_overflow;
  assign len_err   = r_len_err;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_can_rx_frame_buffer.sv
// Directed self-checking bench for can_rx_frame_buffer.
// Timestamp scenario runs when CAN_RX_BUF_TIMESTAMP_EN is defined.
module tb_can_rx_frame_buffer;

  localparam int ASIZE = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [7:0] in_data = '0;
  logic [28:0] in_id = '0;
  logic in_ide = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [28:0] out_id;
  logic out_ide;
  logic [3:0] out_len;
  logic [63:0] out_data;
  logic [ASIZE:0] frame_cnt;
  logic overflow;
  logic len_err;
  logic [15:0] drop_cnt;
`ifdef CAN_RX_BUF_TIMESTAMP_EN
  logic [31:0] out_ts;
`endif

  int errors = 0;
  int checks = 0;

  can_rx_frame_buffer #(.ASIZE(ASIZE)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_id(in_id), .in_ide(in_ide),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_ide(out_ide),
    .out_len(out_len), .out_data(out_data),
    .frame_cnt(frame_cnt), .overflow(overflow),
    .len_err(len_err),
`ifdef CAN_RX_BUF_TIMESTAMP_EN
    .out_ts(out_ts),
`endif
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l,
                      input logic [28:0] id, input logic ide);
    in_valid = 1'b1;
    in_last  = l;
    in_data  = d;
    in_id    = id;
    in_ide   = ide;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset.valid got=%0b exp=0", out_valid);
    end
    checks++;
    if (frame_cnt !== '0) begin
      errors++; $display("FAIL reset.cnt got=%0d exp=0", frame_cnt);
    end
    checks++;
    if ({overflow, len_err} !== 2'b00) begin
      errors++; $display("FAIL reset.pulses got=%b exp=00", {overflow, len_err});
    end
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++; $display("FAIL reset.drop got=%0d exp=0", drop_cnt);
    end
    checks++;
    if ({out_id, out_ide, out_len, out_data} !== '0) begin
      errors++; $display("FAIL reset.fields got=%h exp=0",
                         {out_id, out_ide, out_len, out_data});
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(8'hA1, 1'b0, 29'h123, 1'b0);
    send(8'hB2, 1'b0, 29'h1FFFFFFF, 1'b1);
    send(8'hC3, 1'b1, 29'h0, 1'b1);
    checks++;
    if (frame_cnt !== 5'd1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single.lat0 cnt=%0d valid=%0b exp 1,0",
                         frame_cnt, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single.lat1 got=%0b exp=0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL single.valid got=%0b exp=1", out_valid);
    end
    checks++;
    if (out_len !== 4'd3 || out_data !== 64'h0000_0000_00C3_B2A1) begin
      errors++; $display("FAIL single.data len=%0d data=%h exp 3 c3b2a1",
                         out_len, out_data);
    end
    checks++;
    if (out_id !== 29'h123 || out_ide !== 1'b0) begin
      errors++; $display("FAIL single.id got=%h/%0b exp=123/0", out_id, out_ide);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || frame_cnt !== 5'd0) begin
      errors++; $display("FAIL single.pop valid=%0b cnt=%0d exp 0,0",
                         out_valid, frame_cnt);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d;
    out_ready = 1'b0;
    for (int f = 0; f < 8; f++)
      for (int k = 0; k < 8; k++)
        send(8'(f * 16 + k), k == 7, 29'h12345678, 1'b1);
    tick(); tick();
    checks++;
    if (frame_cnt !== 5'd8) begin
      errors++; $display("FAIL b2b.cnt got=%0d exp=8", frame_cnt);
    end
    checks++;
    if (out_id !== 29'h12345678 || out_ide !== 1'b1 || out_len !== 4'd8) begin
      errors++; $display("FAIL b2b.hdr id=%h ide=%0b len=%0d exp 12345678 1 8",
                         out_id, out_ide, out_len);
    end
    tick();
    checks++;
    if (out_data[7:0] !== 8'h00 || frame_cnt !== 5'd8) begin
      errors++; $display("FAIL b2b.hold d=%h cnt=%0d exp 00 8",
                         out_data[7:0], frame_cnt);
    end
    out_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 8; k++) exp_d[8*k +: 8] = 8'(f * 16 + k);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d) begin
        errors++; $display("FAIL b2b.frame%0d valid=%0b got=%h exp=%h",
                           f, out_valid, out_data, exp_d);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || frame_cnt !== 5'd0) begin
      errors++; $display("FAIL b2b.empty valid=%0b cnt=%0d exp 0,0",
                         out_valid, frame_cnt);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 29'(i), 1'b0);
    send(8'hEE, 1'b1, 29'h7FF, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf.pulse got=%0b exp=1", overflow);
    end
    checks++;
    if (drop_cnt !== 16'd1 || frame_cnt !== 5'd16) begin
      errors++; $display("FAIL ovf.cnt drop=%0d cnt=%0d exp 1 16",
                         drop_cnt, frame_cnt);
    end
    tick();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf.once got=%0b exp=0", overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'(i) || out_len !== 4'd1) begin
        errors++; $display("FAIL ovf.drain%0d valid=%0b d=%h len=%0d exp %h",
                           i, out_valid, out_data, out_len, 64'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || frame_cnt !== 5'd0) begin
      errors++; $display("FAIL ovf.empty valid=%0b cnt=%0d exp 0,0",
                         out_valid, frame_cnt);
    end
  endtask

  task automatic test_len_err();
    int n = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      send(8'(8'h10 + k), k == 9, 29'h2AA, 1'b0);
      if (len_err === 1'b1) n++;
    end
    send(8'h55, 1'b0, 29'h3C, 1'b0);
    if (len_err === 1'b1) n++;
    send(8'h66, 1'b1, 29'h0, 1'b0);
    if (len_err === 1'b1) n++;
    tick();
    if (len_err === 1'b1) n++;
    tick();
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL lenerr.pulses got=%0d exp=1", n);
    end
    checks++;
    if (out_len !== 4'd8 || out_data !== 64'h1716151413121110) begin
      errors++; $display("FAIL lenerr.trunc len=%0d d=%h exp 8 1716151413121110",
                         out_len, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_len !== 4'd2 ||
        out_data !== 64'h6655 || out_id !== 29'h3C) begin
      errors++; $display("FAIL lenerr.next v=%0b len=%0d d=%h id=%h exp 1 2 6655 3c",
                         out_valid, out_len, out_data, out_id);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (frame_cnt !== 5'd0) begin
      errors++; $display("FAIL lenerr.empty cnt=%0d exp=0", frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(8'h01, 1'b1, 29'h1, 1'b0);
    send(8'h02, 1'b1, 29'h2, 1'b0);
    tick(); tick(); tick();
    checks++;
    if (frame_cnt !== 5'd2 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid.pre cnt=%0d valid=%0b exp 2 1",
                         frame_cnt, out_valid);
    end
    send(8'h03, 1'b0, 29'h9, 1'b0);
    send(8'h04, 1'b0, 29'h9, 1'b0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || frame_cnt !== 5'd0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL rstmid.clr valid=%0b cnt=%0d drop=%0d exp 0 0 0",
                         out_valid, frame_cnt, drop_cnt);
    end
    send(8'h77, 1'b1, 29'h55, 1'b0);
    tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_len !== 4'd1 ||
        out_data !== 64'h77 || out_id !== 29'h55) begin
      errors++; $display("FAIL rstmid.new v=%0b len=%0d d=%h id=%h exp 1 1 77 55",
                         out_valid, out_len, out_data, out_id);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

`ifdef CAN_RX_BUF_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [31:0] ts0;
    out_ready = 1'b0;
    send(8'hAA, 1'b1, 29'h10, 1'b0);
    repeat (99) tick();
    send(8'hBB, 1'b1, 29'h11, 1'b0);
    tick(); tick();
    ts0 = out_ts;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hBB ||
        (out_ts - ts0) !== 32'd100) begin
      errors++; $display("FAIL ts.delta v=%0b d=%h diff=%0d exp 1 bb 100",
                         out_valid, out_data, out_ts - ts0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_len_err();
    test_reset_mid();
`ifdef CAN_RX_BUF_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/can_rx_frame_buffer.md
# can_rx_frame_buffer

Receive-side frame buffer for the CAN engine. It consumes the engine's unbuffered byte-per-cycle RX stream (valid/last/data/id/ide) and reassembles each packet into one record: ID, IDE, length and 64-bit payload. Complete records are stored in a frame FIFO and presented to the user through a valid/ready interface. It is the reader counterpart to the engine's buffered TX path; the engine cannot be back-pressured, so overflow is handled by dropping whole frames.

## Interface
- ASIZE, 4: FIFO address width; depth = 2^ASIZE frames.
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  payload byte valid this cycle.
- in_last  in  1  last byte of packet; qualified by in_valid.
- in_data  in  8  payload byte.
- in_id  in  29  packet ID; short IDs in [10:0].
- in_ide  in  1  1 = 29-bit ID, 0 = 11-bit ID.
- out_valid  out  1  head frame available.
- out_ready  in  1  user pops head frame when out_valid & out_ready.
- out_id  out  29  head frame ID.
- out_ide  out  1  head frame IDE.
- out_len  out  4  byte count, 1..8.
- out_data  out  64  payload; arrival byte k is at [8k+7:8k]; unused bytes are 0.
- frame_cnt  out  ASIZE+1  frames stored, including the head frame.
- overflow  out  1  one-cycle pulse when a frame is dropped because the FIFO is full.
- len_err  out  1  one-cycle pulse when a packet has more than 8 bytes.
- drop_cnt  out  16  saturating count of dropped frames.

## Operation
- The assembler has two states: IDLE and COLLECT.
- IDLE, in_valid=1:
  - Latch in_id and in_ide; in_id/in_ide are ignored for the rest of that packet.
  - Clear the assembly register and place the byte at index 0 with byte count 1.
  - If in_last=1, commit immediately and stay in IDLE; otherwise go to COLLECT.
- COLLECT, in_valid=1:
  - Write the byte at index = count and increment count.
  - Bytes 9 and later are discarded and count stays 8. len_err pulses once per packet.
  - If in_last=1, commit and return to IDLE.
- in_valid=0 cycles inside a packet are ignored. There is no timeout.
- Zero-length packets produce no bytes and are never stored.
- Commit writes {id, ide, len, data} when frame_cnt < 2^ASIZE.
  - Otherwise the whole frame is dropped, overflow pulses, and drop_cnt increments, holding at 16'hFFFF.
  - The full check uses frame_cnt registered before the commit cycle. A pop in the same cycle does not rescue the frame.
- Pop advances the read pointer and decrements frame_cnt. A simultaneous commit and pop leaves frame_cnt unchanged.
- Pointers are ASIZE+1 bits and wrap modulo 2^(ASIZE+1). full/empty are decided by comparing the MSB and the address bits.
- The out_* fields are held stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_valid=0, out_id=0, out_ide=0, out_len=0, out_data=0, frame_cnt=0, overflow=0, len_err=0, drop_cnt=0. Assembler state is IDLE and both pointers are 0.
- Reset asserted mid-packet discards the partial frame and all stored frames.
- Latency: with the FIFO empty, out_valid rises 2 clk after the edge that samples in_last.
- frame_cnt updates 1 clk after commit or pop.
- Back-to-back pops: out_valid stays high and the next frame's fields appear the cycle after a pop edge, giving 1 frame/clk sustained.
- A new packet may start the cycle after in_last; the assembler needs no idle gap.
- overflow and len_err are registered and appear 1 clk after the triggering byte.
- FIFO storage may infer BRAM: read is synchronous, feeding an output register with show-ahead refill.

## Configuration
- Macro: CAN_RX_BUF_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit counter, reset to 0 and wrapping, is captured when the first byte of a packet is accepted.
  - The captured value is stored with the frame and presented on extra port out_ts (out, 32), under the same stability and latency rules as out_id.
- Undefined: no counter, no out_ts port, no extra storage width. All other behaviour is identical.

## Test plan
- Single frame, ID 11'h123, ide=0, 3 bytes 8'hA1, 8'hB2, 8'hC3 with last on the third, out_ready=1 -> 2 clk after last:
  - out_valid=1, out_len=3, out_data=64'h0000_0000_00C3_B2A1, out_id=29'h123.
- Eight 8-byte long-ID frames with ID 29'h12345678, sent back-to-back and held with out_ready=0, then drained -> frame_cnt=8; eight frames pop in order on consecutive cycles with payloads intact.
- ASIZE=2: fill 4 frames, send a 5th with out_ready=0 -> overflow pulses once, drop_cnt=1, frame_cnt=4. Draining returns only the first 4 frames.
- 10-byte packet -> len_err pulses once; out_len=8 and out_data holds bytes 0..7. The next packet is assembled normally.
- rstn low for 1 clk while in COLLECT with 2 frames stored -> out_valid=0, frame_cnt=0. A new 1-byte packet yields out_len=1.
- With CAN_RX_BUF_TIMESTAMP_EN defined: two frames whose first bytes arrive 100 clk apart -> their out_ts values differ by exactly 100.
